// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the convolutional encoder/packer.
// Contents:
//   state_e  - frame FSM states (idle, byte load, payload encode, tail encode, flush, done)
//   GK*_*    - default generator masks (K=3 7/5, K=5 23/35 (+27), K=7 171/133, octal)
//   parity() - XOR reduction of a tap-masked shift register (K <= 8)
package conv_enc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEnc,
    StTail,
    StFlush,
    StDone
  } state_e;

  localparam logic [2:0] GK3_0 = 3'o7;
  localparam logic [2:0] GK3_1 = 3'o5;
  localparam logic [4:0] GK5_0 = 5'o23;
  localparam logic [4:0] GK5_1 = 5'o35;
  localparam logic [4:0] GK5_2 = 5'o27;
  localparam logic [6:0] GK7_0 = 7'o171;
  localparam logic [6:0] GK7_1 = 7'o133;

  function automatic logic parity(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_packer_if.sv
// Frame control and byte-stream handshake bundle for conv_encoder_packer.
// Signals:
//   start/frame_len/tail_en/punct_en - frame request, sampled on start
//   in_data/in_valid/in_ready        - payload byte stream (LSB first)
//   out_data/out_valid/out_ready     - packed coded byte stream
//   busy/frame_done                  - frame status
// Modports: master (frame producer / byte consumer), slave (encoder).
interface conv_encoder_packer_if #(
  parameter int unsigned LEN_W = 16
) ();

  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             tail_en;
  logic             punct_en;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, frame_len, tail_en, punct_en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, frame_done
  );

  modport slave (
    input  start, frame_len, tail_en, punct_en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, frame_done
  );

endinterface

// File: rtl/conv_enc_core.sv
// Convolutional encoder core: shift-register state plus generator taps.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   enable_i   - advance the state with bit_i
//   bit_i      - current input bit (newest tap, bit0 of the register)
//   clear_i    - zero the state (frame boundaries)
//   coded_o    - coded bits, coded_o[i] = parity(r & Gi), r = {state, bit_i}
module conv_enc_core
  import conv_enc_pkg::*;
#(
  parameter int unsigned  K     = 5,
  parameter int unsigned  N_OUT = 2,
  parameter logic [K-1:0] G0    = GK5_0,
  parameter logic [K-1:0] G1    = GK5_1,
  parameter logic [K-1:0] G2    = GK5_2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic [N_OUT-1:0] coded_o
);

  logic [K-2:0] state_q;
  logic [K-1:0] r;

  assign r = {state_q, bit_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (clear_i) begin
      state_q <= '0;
    end else if (enable_i) begin
      state_q <= r[K-2:0];
    end
  end

  assign coded_o[0] = parity(8'(r & G0));
  assign coded_o[1] = parity(8'(r & G1));

  if (N_OUT == 3) begin : g_rate3
    assign coded_o[2] = parity(8'(r & G2));
  end

endmodule

// File: rtl/conv_encoder_packer.sv
// Frame-based convolutional encoder with byte input and packed-symbol byte output.
// Payload bits are encoded LSB first, one per cycle; coded bits are appended LSB first
// into a 16-bit accumulator (G(N_OUT-1) first, G0 last) and emitted as bytes.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus_io     - conv_encoder_packer_if.slave: frame control, input and output streams
// Build option: define CONV_ENC_PUNCTURE_EN to add rate-2/3 puncturing (N_OUT=2 only),
// selected per frame with punct_en.
module conv_encoder_packer
  import conv_enc_pkg::*;
#(
  parameter int unsigned  K     = 5,
  parameter int unsigned  N_OUT = 2,
  parameter logic [K-1:0] G0    = GK5_0,
  parameter logic [K-1:0] G1    = GK5_1,
  parameter logic [K-1:0] G2    = GK5_2,
  parameter int unsigned  LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_encoder_packer_if.slave bus_io
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tail_en_q, tail_en_d;
  logic [7:0]       byte_q, byte_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       tail_cnt_q, tail_cnt_d;
  logic [15:0]      acc_q, acc_d, acc_pop, sym_ext;
  logic [4:0]       cnt_q, cnt_d, cnt_pop, nb;
  logic [N_OUT-1:0] coded, sym;
  logic             enc_en, enc_bit, enc_clr;
  logic             push, pad, pop, stall;
  logic             out_valid, in_ready, frame_done;

  assign enc_bit = (state_q == StEnc) ? byte_q[0] : 1'b0;

  conv_enc_core #(
    .K    (K),
    .N_OUT(N_OUT),
    .G0   (G0),
    .G1   (G1),
    .G2   (G2)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(enc_en),
    .bit_i   (enc_bit),
    .clear_i (enc_clr),
    .coded_o (coded)
  );

`ifdef CONV_ENC_PUNCTURE_EN
  // idx_q is the parity of the frame-wide bit index (payload and tail).
  logic punct_q, punct_d, idx_q, idx_d;

  always_comb begin
    punct_d = punct_q;
    idx_d   = idx_q;
    if (state_q == StIdle && bus_io.start) begin
      punct_d = bus_io.punct_en && (N_OUT == 2);
      idx_d   = 1'b0;
    end else if (enc_en) begin
      idx_d = ~idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      punct_q <= 1'b0;
      idx_q   <= 1'b0;
    end else begin
      punct_q <= punct_d;
      idx_q   <= idx_d;
    end
  end
`else
  logic unused_punct;
  assign unused_punct = bus_io.punct_en;
`endif

  // Reverse coded bits so the highest generator lands in the lowest accumulator bit.
  always_comb begin
    sym = '0;
    nb  = 5'(N_OUT);
    for (int unsigned j = 0; j < N_OUT; j++) begin
      sym[j] = coded[N_OUT-1-j];
    end
`ifdef CONV_ENC_PUNCTURE_EN
    if (punct_q && idx_q) begin
      sym    = '0;
      sym[0] = coded[0];
      nb     = 5'd1;
    end
`endif
  end

  assign sym_ext = 16'(sym);

  assign out_valid = (cnt_q >= 5'd8);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    tail_en_d  = tail_en_q;
    byte_d     = byte_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    enc_en     = 1'b0;
    enc_clr    = 1'b0;
    push       = 1'b0;
    pad        = 1'b0;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    // A byte leaving this cycle frees room for the bits encoded this cycle.
    pop     = out_valid && bus_io.out_ready;
    acc_pop = pop ? {8'h00, acc_q[15:8]} : acc_q;
    cnt_pop = pop ? (cnt_q - 5'd8) : cnt_q;
    stall   = (cnt_pop + nb) > 5'd16;

    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          len_d      = bus_io.frame_len;
          tail_en_d  = bus_io.tail_en;
          tail_cnt_d = '0;
          enc_clr    = 1'b1;
          if (bus_io.frame_len == '0) begin
            state_d = bus_io.tail_en ? StTail : StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (bus_io.in_valid) begin
          byte_d    = bus_io.in_data;
          bit_cnt_d = '0;
          state_d   = StEnc;
        end
      end
      StEnc: begin
        if (!stall) begin
          enc_en    = 1'b1;
          push      = 1'b1;
          byte_d    = {1'b0, byte_q[7:1]};
          len_d     = len_q - LEN_W'(1);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (len_q == LEN_W'(1)) begin
            state_d = tail_en_q ? StTail : StFlush;
          end else if (bit_cnt_q == 3'd7) begin
            state_d = StLoad;
          end
        end
      end
      StTail: begin
        if (!stall) begin
          enc_en     = 1'b1;
          push       = 1'b1;
          tail_cnt_d = tail_cnt_q + 3'd1;
          if (tail_cnt_q == 3'(K - 2)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (cnt_pop == 5'd0) begin
          state_d = StDone;
        end else if (cnt_pop < 5'd8) begin
          pad = 1'b1;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        enc_clr    = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    acc_d = acc_pop;
    cnt_d = cnt_pop;
    if (push) begin
      acc_d = acc_pop | (sym_ext << cnt_pop);
      cnt_d = cnt_pop + nb;
    end
    // Bits above cnt are always zero, so padding is just a count bump.
    if (pad) begin
      cnt_d = 5'd8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      tail_en_q  <= 1'b0;
      byte_q     <= '0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      tail_en_q  <= tail_en_d;
      byte_q     <= byte_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.out_valid  = out_valid;
  assign bus_io.out_data   = acc_q[7:0];
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.frame_done = frame_done;

endmodule

// File: tb/tb_conv_encoder_packer.sv
// Self-checking bench for conv_encoder_packer (K=5, rate 1/2, G0=23, G1=35 octal).
module tb_conv_encoder_packer;

  typedef logic [7:0] bq_t[$];

  localparam int          MK  = 5;
  localparam logic [4:0]  MG0 = 5'b10011;
  localparam logic [4:0]  MG1 = 5'b11101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  conv_encoder_packer_if #(.LEN_W(16)) bus ();

  conv_encoder_packer #(
    .K    (5),
    .N_OUT(2),
    .G0   (5'b10011),
    .G1   (5'b11101),
    .G2   (5'b10111),
    .LEN_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_seq(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    end
  endtask

  // Reference: integer history register, emit G1 then G0 per bit, pack LSB first, zero-pad.
  function automatic void model(input int len, input bit tail, input bq_t din, output bq_t exp);
    int   sr;
    int   total;
    bit   bits[$];
    logic [7:0] cur;
    logic [7:0] b8;
    sr = 0;
    exp = {};
    total = len + (tail ? MK - 1 : 0);
    for (int i = 0; i < total; i++) begin
      int b;
      b = 0;
      if (i < len) begin
        cur = din[i / 8];
        b = int'(cur[i % 8]);
      end
      sr = ((sr << 1) | b) & ((1 << MK) - 1);
      bits.push_back(($countones(sr & int'(MG1)) % 2) == 1);
      bits.push_back(($countones(sr & int'(MG0)) % 2) == 1);
    end
    for (int i = 0; i < bits.size(); i += 8) begin
      b8 = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (i + j < bits.size()) b8[j] = bits[i + j];
      end
      exp.push_back(b8);
    end
  endfunction

  // Runs one frame from a sample point (#1 after a rising edge).
  // mode: 0 always ready, 1 random in/out handshakes, 2 out_ready low for 'hold'
  // cycles after the first out_valid. abort_after>0 returns once that many bytes are taken.
  task automatic run_frame(input int len, input bit tail, input bit punct, input bq_t din,
                           input int mode, input int hold, input int abort_after,
                           output bq_t got, output int consumed, output bit done_ok,
                           output int nvalid);
    bit will_in, will_out, stall_prev, seen_valid;
    logic [7:0] capt, prev_data;
    int low_cnt;
    got = {};
    consumed = 0;
    done_ok = 1'b0;
    nvalid = 0;
    will_in = 1'b0;
    will_out = 1'b0;
    stall_prev = 1'b0;
    seen_valid = 1'b0;
    low_cnt = 0;
    capt = 8'h00;
    prev_data = 8'h00;
    bus.start = 1'b1;
    bus.frame_len = 16'(len);
    bus.tail_en = tail;
    bus.punct_en = punct;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (will_in) consumed++;
      if (will_out) got.push_back(capt);
      if (abort_after > 0 && got.size() >= abort_after) break;
      if (bus.frame_done) begin
        done_ok = 1'b1;
        break;
      end
      if (stall_prev && mode == 2) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid) begin
        nvalid++;
        seen_valid = 1'b1;
      end
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (seen_valid && low_cnt < hold) begin
            bus.out_ready = 1'b0;
            low_cnt++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
      bus.in_valid = (consumed < din.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
      bus.in_data = (consumed < din.size()) ? din[consumed] : 8'h00;
      will_in = bus.in_ready && bus.in_valid;
      will_out = bus.out_valid && bus.out_ready;
      capt = bus.out_data;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (done_ok) begin
      @(posedge clk); #1;
      check("frame_done_pulse", bus.frame_done, 0);
      check("busy_after_done", bus.busy, 0);
    end
  endtask

  initial begin
    bq_t got, exp, din;
    int cons, nv, len;
    bit done, tail;

    bus.start = 1'b0;
    bus.frame_len = '0;
    bus.tail_en = 1'b0;
    bus.punct_en = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero payload, one spare byte offered to catch over-consumption.
    din = '{8'h00, 8'h5A};
    run_frame(8, 1'b0, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t1_done", done, 1);
    check("t1_consumed", cons, 1);
    exp = '{8'h00, 8'h00};
    compare_seq("t1", got, exp);

    din = '{8'hFF, 8'h00};
    run_frame(8, 1'b0, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t2_done", done, 1);
    exp = '{8'h47, 8'hAA};
    compare_seq("t2", got, exp);

    run_frame(8, 1'b1, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t2t_done", done, 1);
    check("t2t_consumed", cons, 1);
    exp = '{8'h47, 8'hAA, 8'hED};
    compare_seq("t2t", got, exp);

    // Partial last byte: unused bits discarded, final byte zero-padded.
    run_frame(6, 1'b0, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t3_done", done, 1);
    exp = '{8'h47, 8'h0A};
    compare_seq("t3", got, exp);

    run_frame(0, 1'b0, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t3z_done", done, 1);
    check("t3z_no_valid", nv, 0);
    check("t3z_consumed", cons, 0);

    // Backpressure: out_ready low for 20 cycles after first out_valid.
    run_frame(8, 1'b1, 1'b0, din, 2, 20, 0, got, cons, done, nv);
    check("t4_done", done, 1);
    exp = '{8'h47, 8'hAA, 8'hED};
    compare_seq("t4", got, exp);

    // Reset mid-frame after the first output byte.
    run_frame(8, 1'b1, 1'b0, din, 0, 0, 1, got, cons, done, nv);
    check("t5_first", got.size(), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_out_data", bus.out_data, 0);
    check("t5_in_ready", bus.in_ready, 0);
    check("t5_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_done", bus.frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(8, 1'b1, 1'b0, din, 0, 0, 0, got, cons, done, nv);
    check("t5r_done", done, 1);
    exp = '{8'h47, 8'hAA, 8'hED};
    compare_seq("t5r", got, exp);

`ifdef CONV_ENC_PUNCTURE_EN
    run_frame(8, 1'b0, 1'b1, din, 0, 0, 0, got, cons, done, nv);
    check("t6_done", done, 1);
    exp = '{8'h83, 8'h0D};
    compare_seq("t6", got, exp);
`else
    // Without the puncture build, punct_en must have no effect.
    run_frame(8, 1'b0, 1'b1, din, 0, 0, 0, got, cons, done, nv);
    check("t6_done", done, 1);
    exp = '{8'h47, 8'hAA};
    compare_seq("t6_full_rate", got, exp);
`endif

    // Random frames with random handshakes against the reference model.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 40);
      tail = 1'($urandom_range(0, 1));
      din = {};
      for (int i = 0; i < (len + 7) / 8 + 1; i++) din.push_back(8'($urandom));
      model(len, tail, din, exp);
      run_frame(len, tail, 1'b0, din, 1, 0, 0, got, cons, done, nv);
      check($sformatf("rnd%0d_done", f), done, 1);
      check($sformatf("rnd%0d_consumed", f), cons, (len + 7) / 8);
      compare_seq($sformatf("rnd%0d", f), got, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_packer.md
Name: conv_encoder_packer

Overview:
- Frame-based convolutional encoder with byte-stream input and packed-symbol byte output.
- It is the transmit-side counterpart of the Viterbi decoder, and its output bytes feed the decoder's symbol-byte input directly.
- Generalises the fixed K=3/5/7 rate-1/2 encoding to parametrised K, rate 1/2 or 1/3, optional zero-tail termination, and optional puncturing.

Parameters:
K, 5, constraint length, legal 3..7.
N_OUT, 2, coded bits per input bit, legal 2 or 3.
G0, 5'b10011, generator 0 mask, K bits; bit0 taps the newest input bit.
G1, 5'b11101, generator 1 mask.
G2, 5'b10111, generator 2 mask; used only when N_OUT=3.
LEN_W, 16, width of the frame-length field.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; samples frame_len, tail_en and punct_en; ignored while busy
frame_len  in  LEN_W  number of payload bits in the frame
tail_en  in  1  append K-1 zero bits after the payload
punct_en  in  1  rate-2/3 puncture request; honoured only under the macro
in_data  in  8  payload byte, LSB first
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a byte this cycle
out_data  out  8  packed coded byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
busy  out  1  high from the cycle after start until frame_done
frame_done  out  1  1-cycle pulse after the last byte is accepted

Behaviour:
- Reset: all outputs 0. Encoder state, counters and pack register cleared. FSM in IDLE.
- Encoding: r = {state[K-2:0], bit}. Coded bit g_i = XOR-reduce(r & Gi). state <= r[K-2:0].
- Emission order per input bit: G(N_OUT-1) first, down to G0 last.
- Packing: coded bits are appended LSB-first into a 16-bit accumulator. With N_OUT=2 each symbol is 2 bits, bit1=G0 and bit0=G1, and the byte is {s3,s2,s1,s0}.
- FSM states and transitions:
  - IDLE: on start, go to LOAD. If frame_len=0 and tail_en=0, go straight to DONE instead.
  - LOAD: in_ready=1; a byte transfers when in_valid&&in_ready; then go to ENC.
  - ENC: encodes one payload bit per cycle. After 8 bits, or after the last payload bit, go to LOAD if more payload remains, else TAIL if tail_en, else FLUSH.
  - TAIL: encodes K-1 zero bits, one per cycle, then go to FLUSH.
  - FLUSH: if the accumulator is non-empty, zero-pad to 8 bits and emit; then go to DONE.
  - DONE: pulse frame_done, clear encoder state, return to IDLE.
- Only ceil(frame_len/8) input bytes are consumed. Unused high bits of the last byte are discarded.
- Output handshake:
  - out_valid rises when the accumulator holds 8 or more bits.
  - out_data holds stable until out_valid&&out_ready.
  - The accumulator then shifts right by 8 in the same cycle.
  - ENC and TAIL stall while adding N_OUT bits would exceed 16.
- Throughput: 1 input bit/cycle when unstalled. Latency from the first bit encoded to the first out_valid is at most ceil(8/N_OUT)+1 cycles.
- start while busy is ignored.
- rst_n asserted mid-frame aborts immediately: out_valid drops asynchronously and no frame_done is issued.

Optional Feature:
- Macro: CONV_ENC_PUNCTURE_EN. Valid only with N_OUT=2.
- Macro defined and punct_en=1: rate 2/3. Payload and tail bits with even index emit G1 then G0; odd-index bits emit G0 only. The index resets at start.
- Macro not defined: punct_en is ignored, no puncture logic is synthesised, and the block is always full rate.

Decomposition:
- Package conv_enc_pkg holds:
  - FSM state enum (IDLE, LOAD, ENC, TAIL, FLUSH, DONE).
  - Default generator constants: K3 7/5, K5 23/35, K7 171/133 octal.
  - A parity function.
- Sub-module conv_enc_core: combinational generator taps plus the state register. Interface: enable, bit_in, clear, coded[N_OUT-1:0].

Test Plan:
1. K=5 rate 1/2, frame_len=8, in 0x00, tail off -> out 0x00, 0x00; then frame_done; in_ready consumed exactly 1 byte.
2. K=5, frame_len=8, in 0xFF, tail off -> out 0x47, 0xAA. With tail_en=1 -> 0x47, 0xAA, 0xED.
3. frame_len=6, in 0xFF, tail off -> 0x47, 0x0A (zero-padded). frame_len=0, tail off -> frame_done with no out_valid.
4. Test 2 with out_ready held low for 20 cycles after the first out_valid -> out_data stays 0x47 throughout; no bytes lost or duplicated; final sequence unchanged.
5. rst_n pulsed low mid-frame, after the first output byte -> outputs 0 immediately; a fresh start reproduces test 2 exactly.
6. CONV_ENC_PUNCTURE_EN defined, punct_en=1, frame_len=8, in 0xFF, tail off -> 0x83, 0x0D.
